// File: rtl/mul_div_unit_if.sv
// Handshake and operand bus between the register file read ports and the mul/div unit.
// The unit returns its result, tag and write strobe on the same bundle.
interface mul_div_unit_if #(
    parameter int WIDTH  = 64,
    parameter int REG_AW = 5
);
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [REG_AW-1:0] rd_in;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic [REG_AW-1:0] rd_out;

    modport master (
        output start, op, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: one radix-2 step per clock, WIDTH steps per operation.
// Multiply and divide share one double-width {hi, lo} accumulator.
module mul_div_unit #(
    parameter int WIDTH  = 64,
    parameter int REG_AW = 5
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  opB_q;
    logic [WIDTH-1:0]  result_q;
    logic [REG_AW-1:0] rd_q;
    logic [CW-1:0]     count_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  hi_d;
    logic [WIDTH-1:0]  lo_d;
    logic [WIDTH:0]    mulSum;
    logic [WIDTH:0]    divShift;
    logic              divByZero;

    assign divByZero = bus.op[1] && (bus.rs2_data == '0);

    // Multiply keeps the add carry as the bit shifted into hi; divide is restoring on {rem, quo}.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opB_q} : '0);
        divShift = {hi_q, lo_q[WIDTH-1]};
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (!op_q[1]) begin
            hi_d = mulSum[WIDTH:1];
            lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
        end else if (divShift >= {1'b0, opB_q}) begin
            hi_d = divShift[WIDTH-1:0] - opB_q;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_d = divShift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opB_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (bus.start) begin
                        op_q    <= bus.op;
                        rd_q    <= bus.rd_in;
                        hi_q    <= '0;
                        lo_q    <= bus.op[1] ? bus.rs1_data : bus.rs2_data;
                        opB_q   <= bus.op[1] ? bus.rs2_data : bus.rs1_data;
                        count_q <= '0;
                        // Divide by zero completes immediately with the conventional results.
                        if (divByZero) begin
                            result_q <= bus.op[0] ? bus.rs1_data : '1;
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        result_q <= op_q[0] ? hi_d : lo_d;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, arithmetic results,
// divide-by-zero, busy/back-to-back handling and reset abort.
module tb_mul_div_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   lat;
    int   busyCyc;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one operation and waits (bounded) until done is seen; ends #1 into the done cycle.
    task automatic runOp(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, output int latency, output int busyCount);
        @(negedge clk);
        bus.op       = o;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        latency   = 1;
        busyCount = 0;
        while (bus.done !== 1'b1 && latency < 200) begin
            if (bus.busy === 1'b1) busyCount++;
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.result !== 64'd0) begin bad++; $display("[TB] FAIL reset_result got=%h want=0", bus.result); end
        total++; if (bus.rd_out !== 5'd0) begin bad++; $display("[TB] FAIL reset_rd got=%0d want=0", bus.rd_out); end
        reset = 1'b0;
    endtask

    task automatic test_mul_basic();
        runOp(2'd0, 64'd12, 64'd10, 5'd10, lat, busyCyc);
        total++; if (lat !== 65) begin bad++; $display("[TB] FAIL mul_latency got=%0d want=65", lat); end
        total++; if (busyCyc !== 64) begin bad++; $display("[TB] FAIL mul_busy_cycles got=%0d want=64", busyCyc); end
        total++; if (bus.result !== 64'd120) begin bad++; $display("[TB] FAIL mul_result got=%0d want=120", bus.result); end
        total++; if (bus.rd_out !== 5'd10) begin bad++; $display("[TB] FAIL mul_rd got=%0d want=10", bus.rd_out); end
        @(posedge clk);
        #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL mul_done_pulse got=%b want=0", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mul_busy_after got=%b want=0", bus.busy); end
        total++; if (bus.result !== 64'd120) begin bad++; $display("[TB] FAIL mul_result_hold got=%0d want=120", bus.result); end
    endtask

    task automatic test_mul_wide();
        runOp(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, lat, busyCyc);
        total++; if (bus.result !== 64'h1) begin bad++; $display("[TB] FAIL mulhu_ones got=%h want=1", bus.result); end
        runOp(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, lat, busyCyc);
        total++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("[TB] FAIL mul_ones got=%h want=fffffffffffffffe", bus.result); end
        runOp(2'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd3, lat, busyCyc);
        total++; if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("[TB] FAIL mul_32x32 got=%h want=fffffffe00000001", bus.result); end
        runOp(2'd1, 64'h8000_0000_0000_0000, 64'd4, 5'd4, lat, busyCyc);
        total++; if (bus.result !== 64'd2) begin bad++; $display("[TB] FAIL mulhu_msb got=%h want=2", bus.result); end
    endtask

    task automatic test_div();
        runOp(2'd2, 64'd100, 64'd7, 5'd5, lat, busyCyc);
        total++; if (lat !== 65) begin bad++; $display("[TB] FAIL divu_latency got=%0d want=65", lat); end
        total++; if (bus.result !== 64'd14) begin bad++; $display("[TB] FAIL divu_result got=%0d want=14", bus.result); end
        runOp(2'd3, 64'd100, 64'd7, 5'd6, lat, busyCyc);
        total++; if (lat !== 65) begin bad++; $display("[TB] FAIL remu_latency got=%0d want=65", lat); end
        total++; if (bus.result !== 64'd2) begin bad++; $display("[TB] FAIL remu_result got=%0d want=2", bus.result); end
        runOp(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd7, lat, busyCyc);
        total++; if (bus.result !== 64'h0FFF_FFFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL divu_big got=%h want=0fffffffffffffff", bus.result); end
        runOp(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd8, lat, busyCyc);
        total++; if (bus.result !== 64'hF) begin bad++; $display("[TB] FAIL remu_big got=%h want=f", bus.result); end
    endtask

    task automatic test_div_zero();
        runOp(2'd2, 64'd5, 64'd0, 5'd3, lat, busyCyc);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL dz_latency got=%0d want=1", lat); end
        total++; if (busyCyc !== 0) begin bad++; $display("[TB] FAIL dz_busy got=%0d want=0", busyCyc); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL dz_busy_now got=%b want=0", bus.busy); end
        total++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL dz_divu got=%h want=ffffffffffffffff", bus.result); end
        total++; if (bus.rd_out !== 5'd3) begin bad++; $display("[TB] FAIL dz_rd got=%0d want=3", bus.rd_out); end
        runOp(2'd3, 64'd5, 64'd0, 5'd4, lat, busyCyc);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL dz_remu_latency got=%0d want=1", lat); end
        total++; if (bus.result !== 64'd5) begin bad++; $display("[TB] FAIL dz_remu got=%0d want=5", bus.result); end
    endtask

    task automatic test_busy_ignore();
        int edges;
        @(negedge clk);
        bus.op       = 2'd0;
        bus.rs1_data = 64'd6;
        bus.rs2_data = 64'd7;
        bus.rd_in    = 5'd4;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 1;
        repeat (19) begin
            @(posedge clk);
            #1;
            edges++;
        end
        bus.op       = 2'd2;
        bus.rs1_data = 64'd99;
        bus.rs2_data = 64'd3;
        bus.rd_in    = 5'd9;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        edges++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        total++; if (edges !== 65) begin bad++; $display("[TB] FAIL ignore_latency got=%0d want=65", edges); end
        total++; if (bus.result !== 64'd42) begin bad++; $display("[TB] FAIL ignore_result got=%0d want=42", bus.result); end
        total++; if (bus.rd_out !== 5'd4) begin bad++; $display("[TB] FAIL ignore_rd got=%0d want=4", bus.rd_out); end
        @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL ignore_not_queued got=%b want=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        runOp(2'd0, 64'd5, 64'd5, 5'd1, lat, busyCyc);
        total++; if (bus.result !== 64'd25) begin bad++; $display("[TB] FAIL b2b_first got=%0d want=25", bus.result); end
        bus.op       = 2'd2;
        bus.rs1_data = 64'd81;
        bus.rs2_data = 64'd9;
        bus.rd_in    = 5'd2;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b want=1", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done got=%b want=0", bus.done); end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat !== 65) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=65", lat); end
        total++; if (bus.result !== 64'd9) begin bad++; $display("[TB] FAIL b2b_second got=%0d want=9", bus.result); end
        total++; if (bus.rd_out !== 5'd2) begin bad++; $display("[TB] FAIL b2b_rd got=%0d want=2", bus.rd_out); end
    endtask

    task automatic test_reset_abort();
        int doneSeen;
        @(negedge clk);
        bus.op       = 2'd2;
        bus.rs1_data = 64'd1000;
        bus.rs2_data = 64'd3;
        bus.rd_in    = 5'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done got=%b want=0", bus.done); end
        total++; if (bus.result !== 64'd0) begin bad++; $display("[TB] FAIL abort_result got=%0d want=0", bus.result); end
        doneSeen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) doneSeen++;
        end
        total++; if (doneSeen !== 0) begin bad++; $display("[TB] FAIL abort_no_done got=%0d want=0", doneSeen); end
        runOp(2'd0, 64'd3, 64'd4, 5'd11, lat, busyCyc);
        total++; if (bus.result !== 64'd12) begin bad++; $display("[TB] FAIL abort_then_mul got=%0d want=12", bus.result); end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 2'd0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_in    = '0;
        test_reset();
        test_mul_basic();
        test_mul_wide();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 64-bit unsigned multiply/divide unit for the execute stage.
- Sits directly downstream of the 32x64 register file: consumes its two read-data outputs as operands.
- Returns a result, destination register index and one-cycle write strobe. These connect straight to the register file's write data, write register and RegWrite inputs.
- One radix-2 iteration per clock; start/busy/done handshake.

Parameters:
- WIDTH, 64, operand/result width; iteration count equals WIDTH.
- REG_AW, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on clk edges when not busy.
- op  input  2  operation: 0=MUL (low WIDTH bits of product), 1=MULHU (high WIDTH bits, unsigned), 2=DIVU (unsigned quotient), 3=REMU (unsigned remainder).
- rs1_data  input  WIDTH  operand A / dividend (register file readdata1).
- rs2_data  input  WIDTH  operand B / divisor (register file readdata2).
- rd_in  input  REG_AW  destination register tag.
- busy  output  1  operation in progress; start ignored while high.
- done  output  1  one-cycle pulse, result valid; drives RegWrite.
- result  output  WIDTH  registered result; drives writedata.
- rd_out  output  REG_AW  latched tag; drives writereg.

Behaviour:
- One clock domain. Reset is synchronous and active-high; ports are named clk and reset.
- Reset, which has priority over everything:
  - state=IDLE; busy=0, done=0, result=0, rd_out=0; internal accumulators and counter cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States are IDLE, RUN and DONE. busy=1 exactly while in RUN. done=1 exactly while in DONE.
- IDLE or DONE with start=1 at edge T0:
  - op, rs1_data, rs2_data and rd_in are latched; rd_out updates at T0.
  - Normal case: count=0, next state RUN.
  - Divide by zero (op=2 or 3 with rs2_data=0): skip RUN, go to DONE at T0 (done visible in the cycle after T0). DIVU result = all ones; REMU result = rs1_data.
- DONE with start=0: go to IDLE next edge. done therefore never lasts more than one cycle. Back-to-back operations have no idle bubble.
- RUN:
  - One iteration per edge, on edges T1..T_WIDTH, with count incrementing.
  - At edge T_WIDTH (count==WIDTH-1) the final value is written to result and state becomes DONE.
  - done is high in the cycle following T_WIDTH, i.e. WIDTH+1 edges after start, which is 65 cycles at the default.
- Multiply: shift-add over a 2*WIDTH product register. Multiplier LSB selects add of the multiplicand into the upper half, then shift right 1. MUL takes the low half, MULHU the high half. All arithmetic is unsigned; the add carry is kept as bit 2*WIDTH during the shift.
- Divide: restoring. Per iteration, shift {rem, quo} left 1 bringing in the dividend MSB. If rem >= divisor, subtract and set the quotient LSB. DIVU returns the quotient, REMU the remainder.
- Operand inputs are don't-care after T0: changes to rs1_data, rs2_data, rd_in and op during RUN have no effect.
- start while busy=1 is ignored and not queued.
- result and rd_out hold their values after done until the next completion or reset.
- Undefined op values are impossible (2-bit encoding fully decoded).

Test Plan:
- Reset, then start at T0 with op=0, rs1=12, rs2=10, rd_in=10.
  - Expected: busy=1 for 64 cycles, done=1 for exactly one cycle 65 edges after T0.
  - result=120, rd_out=10; then busy=0, done=0.
- MULHU with rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 → result=0x0000_0000_0000_0001. MUL with the same operands → 0xFFFF_FFFF_FFFF_FFFE.
- DIVU 100/7 → result=14; REMU 100/7 → result=2, each with 65-cycle latency.
- Divide by zero:
  - DIVU rs1=5, rs2=0, rd_in=3 → done in the cycle after T0, result=0xFFFF_FFFF_FFFF_FFFF, rd_out=3, busy never high.
  - REMU rs1=5, rs2=0 → result=5.
- Busy and back-to-back handling:
  - Start a MUL, pulse start with different operands at cycle 20 and change rs1/rs2 → first result unaffected, second request ignored.
  - Assert start in the DONE cycle → new operation begins, busy=1 next cycle.
- Reset asserted at cycle 30 of a DIVU → next cycle busy=0, done=0, result=0. No done pulse follows; a subsequent MUL 3*4 returns 12.
